mem_ctrl: RTL and testbench
===========================

# mem_ctrl

Memory controller between the CPU pipeline and the single byte-wide RAM port. Arbitrates between the instruction-fetch stage (4-byte reads) and the MEM stage (1/2/4-byte loads and stores). Serialises each access into per-byte RAM cycles, little-endian, and returns a one-cycle done pulse to the granted requester. Sits at the top of the CPU, between the IF/MEM stages and the external RAM bus.

## Interface
- No parameters.
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- if_req_i  in  1  IF read request, level, held until if_done_o
- if_addr_i  in  32  IF byte address, always 4-byte transfer
- if_done_o  out  1  one-cycle pulse, if_data_o valid
- if_data_o  out  32  assembled instruction word
- mem_r_req_i  in  1  MEM load request, level
- mem_w_req_i  in  1  MEM store request, level; wins over mem_r_req_i if both high
- mem_addr_i  in  32  MEM byte address
- mem_len_i  in  3  byte count: 1, 2 or 4; any other value treated as 4
- mem_w_data_i  in  32  store data, byte k = bits [8k+7:8k]
- mem_done_o  out  1  one-cycle pulse, load/store complete
- mem_r_data_o  out  32  load data, zero-extended above mem_len_i bytes
- ram_din_i  in  8  RAM read data, valid the cycle after its address
- ram_dout_o  out  8  RAM write data
- ram_a_o  out  32  RAM byte address
- ram_wr_o  out  1  1 = write, 0 = read

## Operation
- States: IDLE, RD, WR, DONE. Owner register (IF/MEM), byte counter k, length N, latched addr/data.
- IDLE: priority MEM write > MEM read > IF read. Grant latches addr, N (IF: 4), write data, owner; k=0; next RD or WR. No request: stay IDLE.
- RD: present ram_a_o = addr+k, ram_wr_o=0 for k=0..N-1. Byte k from ram_din_i captured one cycle later into bits [8k+7:8k]; unused upper bytes 0. After last byte captured -> DONE.
- WR: present ram_a_o = addr+k, ram_dout_o = byte k, ram_wr_o=1 for k=0..N-1; then -> DONE.
- DONE: owner's done pulse high exactly this cycle; no grant evaluated (requester still holds its old request this cycle); next IDLE.
- Request inputs ignored after grant; addr/len/data changes mid-transaction have no effect.
- IF abort: if_req_i low in any RD cycle owned by IF -> next cycle IDLE, no if_done_o, if_data_o unchanged. MEM transactions never abort.
- When no byte is issued (IDLE, DONE, RD data-only cycle): ram_a_o=0, ram_wr_o=0, ram_dout_o=0. No address is ever re-issued (I/O reads have side effects).
- if_data_o / mem_r_data_o hold value until that port's next done. mem_r_data_o not updated by stores.
- Address arithmetic 32-bit, wraps at 0xFFFF_FFFF -> 0.

## Timing
- Reset: state IDLE, all outputs 0, data registers 0, any in-flight access dropped without done. rst wins over every other event.
- Request sampled in IDLE cycle T.
- Read, N bytes: addresses cycles T+1..T+N; byte k on ram_din_i in T+2+k; done in T+N+2 (IF: T+6).
- Write, N bytes: writes cycles T+1..T+N; done in T+N+1.
- Next grant sampled at earliest in T+N+3 (read) / T+N+2 (write).
- Back-to-back throughput: 4-byte read = 6 cycles + 1 IDLE.

## Test plan
- IF read at 0x0000_0010, RAM bytes 0x13,0x05,0x10,0x00 -> ram_a_o 0x10..0x13 in T+1..T+4, ram_wr_o=0, if_done_o only in T+6, if_data_o=0x0010_0513.
- MEM store len 4, addr 0x100, data 0xDEADBEEF -> ram_dout_o EF,BE,AD,DE at 0x100..0x103 with ram_wr_o=1 in T+1..T+4, mem_done_o in T+5, then ram_wr_o=0.
- IF and MEM load len 1 at 0x30000 requested same cycle -> single ram_a_o=0x30000 in T+1, mem_done_o T+3, mem_r_data_o=byte zero-extended; IF address issued T+5; 0x30000 appears exactly once.
- Requests held high through DONE -> no re-grant in DONE cycle; store with len 2 at 0xFFFF_FFFF -> addresses 0xFFFF_FFFF then 0x0000_0000.
- IF read, if_req_i dropped in T+2 -> ram_a_o=0 from T+3, no if_done_o, pending MEM store granted from IDLE T+3.
- rst asserted in T+2 of a 4-byte store -> T+3 all outputs 0, no mem_done_o, only 2 bytes written; new request after reset served normally.

Source files
------------

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates IF fetches and MEM loads/stores onto one
// byte-wide RAM port, little-endian, with a one-cycle done pulse to the granted requester.
//
// state | meaning
// IDLE  | evaluate requests (MEM write > MEM read > IF read), latch the granted access
// RD    | issue read addresses addr+k, capture each byte one cycle later
// WR    | issue write addresses addr+k with byte k of the latched store data
// DONE  | done pulse to the owner, no grant evaluated this cycle
module mem_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_done_o,
    output logic [31:0] if_data_o,
    input  logic        mem_r_req_i,
    input  logic        mem_w_req_i,
    input  logic [31:0] mem_addr_i,
    input  logic [2:0]  mem_len_i,
    input  logic [31:0] mem_w_data_i,
    output logic        mem_done_o,
    output logic [31:0] mem_r_data_o,
    input  logic [7:0]  ram_din_i,
    output logic [7:0]  ram_dout_o,
    output logic [31:0] ram_a_o,
    output logic        ram_wr_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic        owner_mem_q, owner_mem_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [2:0]  len_q, len_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rbuf_q, rbuf_d;
    logic [31:0] if_data_q, if_data_d;
    logic [31:0] mem_rdata_q, mem_rdata_d;

    function automatic logic [2:0] len_decode(input logic [2:0] len);
        logic [2:0] n;
        case (len)
            3'd1:    n = 3'd1;
            3'd2:    n = 3'd2;
            default: n = 3'd4;
        endcase
        return n;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            owner_mem_q <= 1'b0;
            cnt_q       <= '0;
            len_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rbuf_q      <= '0;
            if_data_q   <= '0;
            mem_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_mem_q <= owner_mem_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rbuf_q      <= rbuf_d;
            if_data_q   <= if_data_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_mem_d = owner_mem_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rbuf_d      = rbuf_q;
        if_data_d   = if_data_q;
        mem_rdata_d = mem_rdata_q;
        ram_a_o     = '0;
        ram_wr_o    = 1'b0;
        ram_dout_o  = '0;
        if_done_o   = 1'b0;
        mem_done_o  = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d  = '0;
                rbuf_d = '0;
                if (mem_w_req_i) begin
                    state_d     = S_WR;
                    owner_mem_d = 1'b1;
                    addr_d      = mem_addr_i;
                    len_d       = len_decode(mem_len_i);
                    wdata_d     = mem_w_data_i;
                end else if (mem_r_req_i) begin
                    state_d     = S_RD;
                    owner_mem_d = 1'b1;
                    addr_d      = mem_addr_i;
                    len_d       = len_decode(mem_len_i);
                end else if (if_req_i) begin
                    state_d     = S_RD;
                    owner_mem_d = 1'b0;
                    addr_d      = if_addr_i;
                    len_d       = 3'd4;
                end
            end

            S_RD: begin
                // RAM data lags its address by one cycle, so byte cnt-1 arrives now.
                case (cnt_q)
                    3'd1:    rbuf_d[7:0]   = ram_din_i;
                    3'd2:    rbuf_d[15:8]  = ram_din_i;
                    3'd3:    rbuf_d[23:16] = ram_din_i;
                    3'd4:    rbuf_d[31:24] = ram_din_i;
                    default: ;
                endcase
                if (cnt_q < len_q) begin
                    ram_a_o = addr_q + {29'b0, cnt_q};
                    cnt_d   = cnt_q + 3'd1;
                end
                if (!owner_mem_q && !if_req_i) begin
                    state_d = S_IDLE;
                end else if (cnt_q == len_q) begin
                    state_d = S_DONE;
                    if (owner_mem_q) begin
                        mem_rdata_d = rbuf_d;
                    end else begin
                        if_data_d = rbuf_d;
                    end
                end
            end

            S_WR: begin
                ram_a_o  = addr_q + {29'b0, cnt_q};
                ram_wr_o = 1'b1;
                case (cnt_q[1:0])
                    2'd0: ram_dout_o = wdata_q[7:0];
                    2'd1: ram_dout_o = wdata_q[15:8];
                    2'd2: ram_dout_o = wdata_q[23:16];
                    2'd3: ram_dout_o = wdata_q[31:24];
                endcase
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == len_q - 3'd1) begin
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                if_done_o  = !owner_mem_q;
                mem_done_o = owner_mem_q;
                state_d    = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign if_data_o    = if_data_q;
    assign mem_r_data_o = mem_rdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: a byte RAM environment, a transaction-timing model checked
// every cycle, and directed scenarios with literal expectations.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_done_o;
    logic [31:0] if_data_o;
    logic        mem_r_req_i;
    logic        mem_w_req_i;
    logic [31:0] mem_addr_i;
    logic [2:0]  mem_len_i;
    logic [31:0] mem_w_data_i;
    logic        mem_done_o;
    logic [31:0] mem_r_data_o;
    logic [7:0]  ram_din_i;
    logic [7:0]  ram_dout_o;
    logic [31:0] ram_a_o;
    logic        ram_wr_o;

    mem_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .if_req_i     (if_req_i),
        .if_addr_i    (if_addr_i),
        .if_done_o    (if_done_o),
        .if_data_o    (if_data_o),
        .mem_r_req_i  (mem_r_req_i),
        .mem_w_req_i  (mem_w_req_i),
        .mem_addr_i   (mem_addr_i),
        .mem_len_i    (mem_len_i),
        .mem_w_data_i (mem_w_data_i),
        .mem_done_o   (mem_done_o),
        .mem_r_data_o (mem_r_data_o),
        .ram_din_i    (ram_din_i),
        .ram_dout_o   (ram_dout_o),
        .ram_a_o      (ram_a_o),
        .ram_wr_o     (ram_wr_o)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int n30k  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
        end
    endtask

    // ---------------- RAM environment ----------------
    logic [7:0]  env_mem [logic [31:0]];
    logic [31:0] pend_a = '0;

    function automatic logic [7:0] env_rd(input logic [31:0] a);
        return env_mem.exists(a) ? env_mem[a] : 8'h00;
    endfunction

    always @(negedge clk) begin
        if (ram_wr_o) env_mem[ram_a_o] = ram_dout_o;
        pend_a = ram_a_o;
    end

    always @(posedge clk) begin
        #1 ram_din_i = env_rd(pend_a);
    end

    // ---------------- timing model ----------------
    typedef struct packed {
        logic [31:0] a;
        logic        wr;
        logic [7:0]  dout;
        logic        ifd;
        logic        memd;
    } ev_t;

    ev_t         exp_ev      [int];
    logic [31:0] ifdata_upd  [int];
    logic [31:0] memdata_upd [int];
    int          next_free = 0;
    bit          if_active = 0;
    int          if_t      = 0;

    function automatic int nbytes(input logic [2:0] l);
        return (l == 3'd1) ? 1 : (l == 3'd2) ? 2 : 4;
    endfunction

    task automatic prune(input int c);
        int ks[$];
        foreach (exp_ev[k]) if (k > c) ks.push_back(k);
        foreach (ks[i]) exp_ev.delete(ks[i]);
        ks.delete();
        foreach (ifdata_upd[k]) if (k > c) ks.push_back(k);
        foreach (ks[i]) ifdata_upd.delete(ks[i]);
        ks.delete();
        foreach (memdata_upd[k]) if (k > c) ks.push_back(k);
        foreach (ks[i]) memdata_upd.delete(ks[i]);
    endtask

    task automatic sched_write(input int c, input logic [31:0] a, input int n, input logic [31:0] d);
        ev_t e;
        for (int k = 0; k < n; k++) begin
            e      = '0;
            e.a    = a + k;
            e.wr   = 1'b1;
            e.dout = d[8*k +: 8];
            exp_ev[c + 1 + k] = e;
        end
        e      = '0;
        e.memd = 1'b1;
        exp_ev[c + n + 1] = e;
        next_free = c + n + 2;
    endtask

    task automatic sched_read(input int c, input logic [31:0] a, input int n, input bit is_mem);
        ev_t         e;
        logic [31:0] d;
        logic [31:0] ak;
        d = '0;
        for (int k = 0; k < n; k++) begin
            ak = a + k;
            e   = '0;
            e.a = ak;
            exp_ev[c + 1 + k] = e;
            d[8*k +: 8] = env_rd(ak);
        end
        e = '0;
        if (is_mem) begin
            e.memd = 1'b1;
            memdata_upd[c + n + 2] = d;
        end else begin
            e.ifd = 1'b1;
            ifdata_upd[c + n + 2] = d;
        end
        exp_ev[c + n + 2] = e;
        next_free = c + n + 3;
    endtask

    always @(posedge clk) begin : model
        int c;
        c = cyc;
        if (rst) begin
            prune(c);
            ifdata_upd[c + 1]  = '0;
            memdata_upd[c + 1] = '0;
            next_free = c + 1;
            if_active = 0;
        end else if (if_active && c > if_t && c <= if_t + 5 && !if_req_i) begin
            prune(c);
            next_free = c + 1;
            if_active = 0;
        end else if (c >= next_free) begin
            if (mem_w_req_i) begin
                sched_write(c, mem_addr_i, nbytes(mem_len_i), mem_w_data_i);
            end else if (mem_r_req_i) begin
                sched_read(c, mem_addr_i, nbytes(mem_len_i), 1'b1);
            end else if (if_req_i) begin
                sched_read(c, if_addr_i, 4, 1'b0);
                if_active = 1;
                if_t      = c;
            end
        end
        cyc = cyc + 1;
    end

    logic [31:0] exp_if  = '0;
    logic [31:0] exp_mem = '0;

    always @(negedge clk) begin : compare
        ev_t e;
        if (ram_a_o == 32'h0003_0000) n30k++;
        if (cyc >= 1) begin
            e = '0;
            if (exp_ev.exists(cyc)) e = exp_ev[cyc];
            if (ifdata_upd.exists(cyc))  exp_if  = ifdata_upd[cyc];
            if (memdata_upd.exists(cyc)) exp_mem = memdata_upd[cyc];
            chk("ram_a_o",      ram_a_o,               e.a);
            chk("ram_wr_o",     {31'b0, ram_wr_o},     {31'b0, e.wr});
            chk("ram_dout_o",   {24'b0, ram_dout_o},   {24'b0, e.dout});
            chk("if_done_o",    {31'b0, if_done_o},    {31'b0, e.ifd});
            chk("mem_done_o",   {31'b0, mem_done_o},   {31'b0, e.memd});
            chk("if_data_o",    if_data_o,             exp_if);
            chk("mem_r_data_o", mem_r_data_o,          exp_mem);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_done(input bit want_if, input int t0, input int maxc, output int lat);
        lat = -1;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (want_if ? if_done_o : mem_done_o) begin
                lat = cyc - t0;
                break;
            end
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin : stim
        int t0;
        int lat;
        rst = 1'b1;
        if_req_i = 0; if_addr_i = '0;
        mem_r_req_i = 0; mem_w_req_i = 0; mem_addr_i = '0; mem_len_i = '0; mem_w_data_i = '0;
        ram_din_i = '0;
        env_mem[32'h10] = 8'h13; env_mem[32'h11] = 8'h05; env_mem[32'h12] = 8'h10; env_mem[32'h13] = 8'h00;
        env_mem[32'h40] = 8'h37; env_mem[32'h41] = 8'h12; env_mem[32'h42] = 8'h00; env_mem[32'h43] = 8'h00;
        env_mem[32'h0003_0000] = 8'h9C;
        env_mem[32'h200] = 8'h11; env_mem[32'h201] = 8'h22; env_mem[32'h202] = 8'h33; env_mem[32'h203] = 8'h44;
        env_mem[32'h402] = 8'hEE;
        repeat (3) step();
        chk("reset_if_data",  if_data_o,    32'h0);
        chk("reset_mem_data", mem_r_data_o, 32'h0);
        chk("reset_ram_a",    ram_a_o,      32'h0);
        rst = 1'b0;
        step();

        // IF fetch at 0x10
        if_req_i = 1; if_addr_i = 32'h10; t0 = cyc;
        wait_done(1'b1, t0, 20, lat);
        chk("if_lat", lat, 6);
        chk("if_word", if_data_o, 32'h0010_0513);
        if_req_i = 0;
        step();

        // store 4 bytes at 0x100
        mem_w_req_i = 1; mem_addr_i = 32'h100; mem_len_i = 3'd4; mem_w_data_i = 32'hDEAD_BEEF; t0 = cyc;
        wait_done(1'b0, t0, 20, lat);
        chk("st4_lat", lat, 5);
        mem_w_req_i = 0;
        chk("st4_b0", {24'b0, env_rd(32'h100)}, 32'hEF);
        chk("st4_b3", {24'b0, env_rd(32'h103)}, 32'hDE);
        step();

        // load 2 bytes from 0x102, zero-extended
        mem_r_req_i = 1; mem_addr_i = 32'h102; mem_len_i = 3'd2; t0 = cyc;
        wait_done(1'b0, t0, 20, lat);
        chk("ld2_lat", lat, 4);
        chk("ld2_data", mem_r_data_o, 32'h0000_DEAD);
        mem_r_req_i = 0;
        step();

        // len 3 decodes as 4
        mem_r_req_i = 1; mem_addr_i = 32'h100; mem_len_i = 3'd3; t0 = cyc;
        wait_done(1'b0, t0, 20, lat);
        chk("ld3_lat", lat, 6);
        chk("ld3_data", mem_r_data_o, 32'hDEAD_BEEF);
        mem_r_req_i = 0;
        step();

        // IF and MEM load requested together: MEM first, IF afterwards
        n30k = 0;
        if_req_i = 1; if_addr_i = 32'h40;
        mem_r_req_i = 1; mem_addr_i = 32'h0003_0000; mem_len_i = 3'd1; t0 = cyc;
        wait_done(1'b0, t0, 20, lat);
        chk("arb_mem_lat", lat, 3);
        chk("arb_mem_data", mem_r_data_o, 32'h0000_009C);
        mem_r_req_i = 0;
        wait_done(1'b1, t0, 20, lat);
        chk("arb_if_lat", lat, 10);
        chk("arb_if_data", if_data_o, 32'h0000_1237);
        if_req_i = 0;
        chk("arb_once", n30k, 1);
        step();

        // store len 2 across the address wrap, request held through DONE
        mem_w_req_i = 1; mem_addr_i = 32'hFFFF_FFFF; mem_len_i = 3'd2; mem_w_data_i = 32'hAB00_1234; t0 = cyc;
        wait_done(1'b0, t0, 20, lat);
        chk("wrap_lat", lat, 3);
        @(posedge clk);
        #1 mem_w_req_i = 0;
        step();
        chk("wrap_hi", {24'b0, env_rd(32'hFFFF_FFFF)}, 32'h34);
        chk("wrap_lo", {24'b0, env_rd(32'h0)},         32'h12);
        step();

        // IF abort in T+2 with a store waiting
        if_req_i = 1; if_addr_i = 32'h200; t0 = cyc;
        step();
        step();
        if_req_i = 0;
        mem_w_req_i = 1; mem_addr_i = 32'h300; mem_len_i = 3'd1; mem_w_data_i = 32'h0000_005A;
        step();
        chk("abort_ram_a", ram_a_o, 32'h0);
        wait_done(1'b0, t0, 20, lat);
        chk("abort_st_lat", lat, 5);
        chk("abort_if_data", if_data_o, 32'h0000_1237);
        mem_w_req_i = 0;
        step();
        chk("abort_st_byte", {24'b0, env_rd(32'h300)}, 32'h5A);

        // reset in T+2 of a 4-byte store
        mem_w_req_i = 1; mem_addr_i = 32'h400; mem_len_i = 3'd4; mem_w_data_i = 32'h1122_3344;
        step();
        step();
        rst = 1'b1; mem_w_req_i = 0;
        step();
        rst = 1'b0;
        chk("rst_wr",       {31'b0, ram_wr_o},   32'h0);
        chk("rst_done",     {31'b0, mem_done_o}, 32'h0);
        chk("rst_if_data",  if_data_o,           32'h0);
        chk("rst_mem_data", mem_r_data_o,        32'h0);
        chk("rst_b0", {24'b0, env_rd(32'h400)}, 32'h44);
        chk("rst_b1", {24'b0, env_rd(32'h401)}, 32'h33);
        chk("rst_b2", {24'b0, env_rd(32'h402)}, 32'hEE);
        mem_r_req_i = 1; mem_addr_i = 32'h100; mem_len_i = 3'd4; t0 = cyc;
        wait_done(1'b0, t0, 20, lat);
        chk("post_rst_lat", lat, 6);
        chk("post_rst_data", mem_r_data_o, 32'hDEAD_BEEF);
        mem_r_req_i = 0;

        repeat (4) step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
